// File: rtl/rst_gen_sync.sv
// Reset generator: async assert, synchronized and stretched deassert, plus a
// software reset path with cause tracking and a saturating software-reset count.
module rst_gen_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_i,
  output logic       rst_n_o,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] sw_rst_cnt_o
);

  localparam int unsigned      CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]       CAUSE_EXT = 2'b01;
  localparam logic [1:0]       CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    IN_RESET,
    HOLD,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_ok;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rst_n_d;
  logic                   done_d;
  logic [1:0]             cause_d;
  logic [7:0]             sw_cnt_d;

  // Only the chain sees the raw rst_n release, so any metastability stays here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IN_RESET;
      cnt_q        <= '0;
      rst_n_o      <= 1'b0;
      rst_done_o   <= 1'b0;
      rst_cause_o  <= CAUSE_EXT;
      sw_rst_cnt_o <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_n_o      <= rst_n_d;
      rst_done_o   <= done_d;
      rst_cause_o  <= cause_d;
      sw_rst_cnt_o <= sw_cnt_d;
    end
  end

  // Outputs are computed as next-state values so every output leaves a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rst_n_d  = rst_n_o;
    done_d   = 1'b0;
    cause_d  = rst_cause_o;
    sw_cnt_d = sw_rst_cnt_o;

    unique case (state_q)
      IN_RESET: begin
        cnt_d   = '0;
        rst_n_d = 1'b0;
        if (sync_ok) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        rst_n_d = 1'b0;
        if (sw_rst_i) begin
          cnt_d   = '0;
          cause_d = CAUSE_SW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          rst_n_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        rst_n_d = 1'b1;
        if (sw_rst_i) begin
          state_d = HOLD;
          cnt_d   = '0;
          rst_n_d = 1'b0;
          cause_d = CAUSE_SW;
          if (sw_rst_cnt_o != '1) begin
            sw_cnt_d = sw_rst_cnt_o + 8'd1;
          end
        end
      end

      default: begin
        state_d = IN_RESET;
        cnt_d   = '0;
        rst_n_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_gen_sync.sv
// Self-checking bench for rst_gen_sync: deadline-based reference model compared
// every cycle, plus directed literal checks of the key timing points.
module tb_rst_gen_sync;

  localparam int unsigned S = 2;
  localparam int unsigned H = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_i = 1'b0;
  logic       rst_n_o;
  logic       rst_done_o;
  logic [1:0] rst_cause_o;
  logic [7:0] sw_rst_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  rst_gen_sync #(
    .SYNC_STAGES(S),
    .HOLD_CYCLES(H)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_rst_i    (sw_rst_i),
    .rst_n_o     (rst_n_o),
    .rst_done_o  (rst_done_o),
    .rst_cause_o (rst_cause_o),
    .sw_rst_cnt_o(sw_rst_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: edges are numbered from release; the output rises at a
  // deadline edge that any accepted software request pushes out to now+H.
  int unsigned m_edge      = 0;
  int unsigned m_hold_from = S + 1;
  int unsigned m_rise_at   = S + 1 + H;
  bit          m_out       = 1'b0;
  bit          m_done      = 1'b0;
  logic [1:0]  m_cause     = 2'b01;
  int unsigned m_cnt       = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge    = 0;
      m_rise_at = S + 1 + H;
      m_out     = 1'b0;
      m_done    = 1'b0;
      m_cause   = 2'b01;
      m_cnt     = 0;
    end else begin
      m_edge = m_edge + 1;
      m_done = 1'b0;
      if (m_edge > m_hold_from) begin
        if (sw_rst_i) begin
          if (m_out) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          m_out     = 1'b0;
          m_cause   = 2'b10;
          m_rise_at = m_edge + H;
        end else if (!m_out && m_edge == m_rise_at) begin
          m_out  = 1'b1;
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_rst_n_o", rst_n_o, m_out);
    check("model_rst_done_o", rst_done_o, m_done);
    check("model_rst_cause_o", rst_cause_o, m_cause);
    check("model_sw_rst_cnt_o", sw_rst_cnt_o, m_cnt);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 3 * H && !seen; k++) begin
      step(1);
      if (rst_done_o === 1'b1) seen = 1'b1;
    end
    check("wait_done_timeout", seen, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst_n_o"}, rst_n_o, 1'b0);
    check({tag, "_done"}, rst_done_o, 1'b0);
    check({tag, "_cause"}, rst_cause_o, 2'b01);
    check({tag, "_cnt"}, sw_rst_cnt_o, 8'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on
    step(1);
    check_reset_vals("por_in_reset");
    step(4);
    rst_n = 1'b1;
    step(18);
    check("por_edge18_low", rst_n_o, 1'b0);
    step(1);
    check("por_edge19_high", rst_n_o, 1'b1);
    check("por_edge19_done", rst_done_o, 1'b1);
    check("por_cause", rst_cause_o, 2'b01);
    check("por_cnt", sw_rst_cnt_o, 8'd0);
    step(1);
    check("por_done_one_cycle", rst_done_o, 1'b0);

    // Single software reset from RUN
    step(3);
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    check("sw_low_after_E", rst_n_o, 1'b0);
    check("sw_cause", rst_cause_o, 2'b10);
    check("sw_cnt_1", sw_rst_cnt_o, 8'd1);
    step(15);
    check("sw_low_E15", rst_n_o, 1'b0);
    step(1);
    check("sw_high_E16", rst_n_o, 1'b1);
    check("sw_done_E16", rst_done_o, 1'b1);

    // Request while counter is 10 restarts the hold
    step(2);
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    step(10);
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    step(15);
    check("hold_req_low_F15", rst_n_o, 1'b0);
    step(1);
    check("hold_req_high_F16", rst_n_o, 1'b1);
    check("hold_req_cnt_2", sw_rst_cnt_o, 8'd2);
    check("hold_req_cause", rst_cause_o, 2'b10);

    // External reset mid-HOLD, then request held across IN_RESET
    step(2);
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    step(5);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("ext_mid_hold");
    step(3);
    sw_rst_i = 1'b1;
    rst_n = 1'b1;
    step(3);
    sw_rst_i = 1'b0;
    step(15);
    check("ext_rel_edge18_low", rst_n_o, 1'b0);
    step(1);
    check("ext_rel_edge19_high", rst_n_o, 1'b1);
    check("ign_req_cause", rst_cause_o, 2'b01);
    check("ign_req_cnt", sw_rst_cnt_o, 8'd0);

    // Held request for 40 cycles counts once
    step(2);
    sw_rst_i = 1'b1;
    step(40);
    sw_rst_i = 1'b0;
    check("held_low", rst_n_o, 1'b0);
    check("held_cnt_1", sw_rst_cnt_o, 8'd1);
    step(15);
    check("held_low_last15", rst_n_o, 1'b0);
    step(1);
    check("held_high_last16", rst_n_o, 1'b1);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      step(1);
      sw_rst_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        step($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    sw_rst_i = 1'b0;

    // Saturation
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    wait_done();
    for (int i = 0; i < 300; i++) begin
      step(1);
      sw_rst_i = 1'b1;
      step(1);
      sw_rst_i = 1'b0;
      wait_done();
    end
    check("sat_cnt_255", sw_rst_cnt_o, 8'd255);
    check("sat_cause", rst_cause_o, 2'b10);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rst_gen_sync.md
# rst_gen_sync

Reset generator that produces the active-low reset consumed by every flip-flop in the design, including all `rst_n`-reset registers downstream. It accepts the board-level asynchronous active-low reset and a synchronous software reset request. It outputs a reset that asserts immediately, deasserts synchronously to `clk`, and is stretched to a minimum hold length. It also records the cause of the last reset and counts software resets.

## Interface
- `SYNC_STAGES`, 2: depth of the deassertion synchronizer chain; legal values are 2 or more.
- `HOLD_CYCLES`, 16: number of cycles `rst_n_o` stays low after synchronization; legal values are 1 to 256. The internal counter is as wide as needed to hold `HOLD_CYCLES-1`.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low; clears all state immediately when low.
- `sw_rst_i`  input  1  software reset request, synchronous to `clk`, sampled on the rising edge.
- `rst_n_o`  output  1  generated reset, active-low, registered.
- `rst_done_o`  output  1  one-cycle pulse on the edge where `rst_n_o` goes 1.
- `rst_cause_o`  output  2  last reset source: 01 = external (`rst_n`), 10 = software; 00 and 11 are never driven.
- `sw_rst_cnt_o`  output  8  number of software resets since the last external reset; saturates at 255.

## Operation
- Asynchronous reset (`rst_n`=0):
  - Clears the sync chain, counter and state (state → `IN_RESET`).
  - Outputs: `rst_n_o`=0, `rst_done_o`=0, `rst_cause_o`=01, `sw_rst_cnt_o`=0.
  - These values apply with no clock edge required.
- Sync chain: `SYNC_STAGES` flops shifting in constant 1, all cleared by `rst_n`. `sync_ok` is the last stage.
- State machine:
  - `IN_RESET`: counter held at 0, `rst_n_o`=0, `sw_rst_i` ignored. When `sync_ok`=1 → `HOLD` with counter=0.
  - `HOLD`: `rst_n_o`=0, counter +1 per edge.
    - Counter == `HOLD_CYCLES-1` and `sw_rst_i`=0 → `RUN`, `rst_n_o`=1, `rst_done_o`=1.
    - `sw_rst_i`=1 (including at the terminal count) → counter=0, stay in `HOLD`, `rst_cause_o`=10. `sw_rst_cnt_o` is unchanged.
  - `RUN`: `rst_n_o`=1, `rst_done_o`=0 after its single cycle.
    - `sw_rst_i`=1 → `HOLD`, counter=0, `rst_n_o`=0 on that edge.
    - On the same edge, `rst_cause_o`=10 and `sw_rst_cnt_o` increments, saturating at 255.
- `sw_rst_cnt_o` increments only on `RUN`→`HOLD` transitions. A held-high request counts once.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Assertion via `rst_n`: asynchronous; `rst_n_o` falls without a clock.
- Deassertion via `rst_n`: the first rising edge after `rst_n` rises is edge 1.
  - Edges 1..`SYNC_STAGES`: chain fills.
  - Edge `SYNC_STAGES+1`: enter `HOLD`.
  - Edge `SYNC_STAGES+1+HOLD_CYCLES`: `rst_n_o` goes 1. With defaults this is edge 19.
- Software reset: request sampled at edge E → `rst_n_o`=0 after E. `rst_n_o` returns to 1 at edge E+`HOLD_CYCLES`, so it is low for exactly `HOLD_CYCLES` cycles.
- `rst_done_o` is high for exactly one cycle, coincident with the first high cycle of `rst_n_o`.
- `rst_n` falling mid-`HOLD` or mid-`RUN`: immediate full clear. The cause returns to 01, so an external reset overrides a software cause.
- `rst_n` rising close to a clock edge: metastability is confined to the chain; only the extra edge of latency may vary.

## Test plan
- Power-on:
  - Stimulus: `rst_n`=0 for 5 cycles, released between edges.
  - Required response: `rst_n_o`=0 through edge 18 and 1 after edge 19. `rst_done_o`=1 for one cycle. `rst_cause_o`=01, `sw_rst_cnt_o`=0.
- Software reset:
  - Stimulus: in `RUN`, `sw_rst_i`=1 for one cycle at edge E.
  - Required response: `rst_n_o` low after E and high after E+16. `rst_cause_o`=10, `sw_rst_cnt_o`=1, one `rst_done_o` pulse.
- Request during `HOLD`:
  - Stimulus: `sw_rst_i` pulsed when the counter is 10.
  - Required response: counter restarts, `rst_n_o` stays low for 16 further cycles, `sw_rst_cnt_o` unchanged.
- External reset mid-`HOLD`:
  - Stimulus: `rst_n` dropped between edges while in `HOLD`.
  - Required response: outputs go to reset values with no clock edge. `rst_cause_o`=01, `sw_rst_cnt_o`=0. On release, the 19-edge sequence repeats.
- Held request and ignored request:
  - Stimulus: `sw_rst_i` held high 40 cycles in `RUN`.
  - Required response: `rst_n_o` stays 0, `sw_rst_cnt_o` increments by 1 only, release occurs 16 edges after the last high sample.
  - Stimulus: `sw_rst_i`=1 during `IN_RESET`.
  - Required response: no effect.
- Saturation:
  - Stimulus: 300 separate software resets.
  - Required response: `sw_rst_cnt_o`=255, with no wrap to 0.
